// File: rtl/fetch_unit.sv
// Instruction fetch stage: small program-loadable instruction memory, PC/IR
// registers and an EMPTY/RUN/HALT sequencer with branch/jump squash.
module fetch_unit #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [5:0]  HALT_OP    = 6'h3F,
   localparam int         AW         = $clog2(IMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          branch_taken,
   input  logic          jump,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data,
   output logic [5:0]    op,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [4:0]    shamt,
   output logic [5:0]    funct,
   output logic [31:0]   pc,
   output logic [31:0]   pc_ir,
   output logic          instr_valid,
   output logic          halted
);

   typedef enum logic [1:0] {S_EMPTY, S_RUN, S_HALT} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_pc, w_pc_nxt;
   logic [31:0]   r_pc_ir, w_pc_ir_nxt;
   logic [31:0]   r_ir, w_ir_nxt;
   logic          r_valid, w_valid_nxt;

   logic [31:0]   r_mem [IMEM_DEPTH];
   logic [31:0]   w_fetch;
   logic [31:0]   w_pc_ir_plus4;
   logic [31:0]   w_jump_tgt;
   logic [31:0]   w_branch_tgt;
   logic          w_is_halt;
   logic          w_redirect;

   // NOTE: the memory has no reset; program contents must survive rst_n.
   always_ff @(posedge clk) begin
      if (prog_we)
         r_mem[prog_addr] <= prog_data;
   end

   // Upper PC bits are dropped, so fetch addresses wrap over the memory.
   assign w_fetch       = r_mem[r_pc[AW+1:2]];
   assign w_pc_ir_plus4 = r_pc_ir + 32'd4;
   assign w_jump_tgt    = {w_pc_ir_plus4[31:28], r_ir[25:0], 2'b00};
   assign w_branch_tgt  = w_pc_ir_plus4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
   assign w_is_halt     = r_valid && (r_ir[31:26] == HALT_OP);
   assign w_redirect    = r_valid && (jump || branch_taken);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_pc    <= '0;
         r_pc_ir <= '0;
         r_ir    <= '0;
         r_valid <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment only.
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_pc_ir <= w_pc_ir_nxt;
         r_ir    <= w_ir_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a hold default first so no latch is inferred.
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pc_ir_nxt = r_pc_ir;
      w_ir_nxt    = r_ir;
      w_valid_nxt = r_valid;
      if (!stall) begin
         case (r_state)
            S_EMPTY: begin
               w_ir_nxt    = w_fetch;
               w_pc_ir_nxt = r_pc;
               w_pc_nxt    = r_pc + 32'd4;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_RUN;
            end
            S_RUN: begin
               if (w_is_halt) begin
                  w_state_nxt = S_HALT;
                  w_ir_nxt    = '0;
                  w_valid_nxt = 1'b0;
               end else if (w_redirect) begin
                  // Wrong-path word fetched this cycle is squashed to a bubble.
                  w_pc_nxt    = jump ? w_jump_tgt : w_branch_tgt;
                  w_ir_nxt    = '0;
                  w_valid_nxt = 1'b0;
               end else begin
                  w_ir_nxt    = w_fetch;
                  w_pc_ir_nxt = r_pc;
                  w_pc_nxt    = r_pc + 32'd4;
                  w_valid_nxt = 1'b1;
               end
            end
            S_HALT: ;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   assign op          = r_ir[31:26];
   assign rs          = r_ir[25:21];
   assign rt          = r_ir[20:16];
   assign rd          = r_ir[15:11];
   assign shamt       = r_ir[10:6];
   assign funct       = r_ir[5:0];
   assign pc          = r_pc;
   assign pc_ir       = r_pc_ir;
   assign instr_valid = r_valid;
   assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector tables for the main flows,
// hand-written sequences for reset-in-flight and program-write timing.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, branch_taken, jump, prog_we;
   logic [5:0]  prog_addr;
   logic [31:0] prog_data;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] pc, pc_ir;
   logic        instr_valid, halted;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(.IMEM_DEPTH(64), .HALT_OP(6'h3F)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .jump(jump), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .pc(pc), .pc_ir(pc_ir), .instr_valid(instr_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, br, jmp;
      logic [31:0] pc, pc_ir, ir;
      logic        valid, halted, chk_pc_ir;
   } vec_t;

   vec_t vt [0:33];

   function automatic vec_t mk(logic s, logic b, logic j, logic [31:0] p,
                               logic [31:0] pi, logic [31:0] ir, logic v,
                               logic h, logic cp);
      vec_t r;
      r.stall = s; r.br = b; r.jmp = j; r.pc = p; r.pc_ir = pi; r.ir = ir;
      r.valid = v; r.halted = h; r.chk_pc_ir = cp;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ir_out();
      return {op, rs, rt, rd, shamt, funct};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int addr, input logic [31:0] data);
      prog_we = 1'b1; prog_addr = 6'(addr); prog_data = data;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic reset_assert();
      @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic reset_release(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check({tag, " rst pc"},    pc, 32'h0);
      check({tag, " rst pc_ir"}, pc_ir, 32'h0);
      check({tag, " rst ir"},    ir_out(), 32'h0);
      check({tag, " rst valid"}, 32'(instr_valid), 32'h0);
      check({tag, " rst halted"}, 32'(halted), 32'h0);
   endtask

   task automatic run_range(input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++) begin
         stall = vt[i].stall; branch_taken = vt[i].br; jump = vt[i].jmp;
         tick();
         check($sformatf("%s[%0d] pc", tag, i), pc, vt[i].pc);
         if (vt[i].chk_pc_ir)
            check($sformatf("%s[%0d] pc_ir", tag, i), pc_ir, vt[i].pc_ir);
         check($sformatf("%s[%0d] ir", tag, i), ir_out(), vt[i].ir);
         check($sformatf("%s[%0d] valid", tag, i), 32'(instr_valid), 32'(vt[i].valid));
         check($sformatf("%s[%0d] halted", tag, i), 32'(halted), 32'(vt[i].halted));
      end
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
   endtask

   initial begin
      // Sequential fetch and a three-cycle stall (jump/branch ignored while stalled).
      vt[0]  = mk(0,0,0, 32'h04, 32'h00, 32'h00430820, 1,0,1);
      vt[1]  = mk(0,0,0, 32'h08, 32'h04, 32'hAC410000, 1,0,1);
      vt[2]  = mk(0,0,0, 32'h0C, 32'h08, 32'h8C440000, 1,0,1);
      vt[3]  = mk(1,0,0, 32'h0C, 32'h08, 32'h8C440000, 1,0,1);
      vt[4]  = mk(1,1,1, 32'h0C, 32'h08, 32'h8C440000, 1,0,1);
      vt[5]  = mk(1,0,0, 32'h0C, 32'h08, 32'h8C440000, 1,0,1);
      vt[6]  = mk(0,0,0, 32'h10, 32'h0C, 32'h00000003, 1,0,1);
      vt[7]  = mk(0,0,0, 32'h14, 32'h10, 32'h00000004, 1,0,1);
      // Taken branch at pc_ir=8, redirect ignored in the squashed cycle.
      vt[8]  = mk(0,0,0, 32'h04, 32'h00, 32'h00430820, 1,0,1);
      vt[9]  = mk(0,0,0, 32'h08, 32'h04, 32'hAC410000, 1,0,1);
      vt[10] = mk(0,0,0, 32'h0C, 32'h08, 32'h10000003, 1,0,1);
      vt[11] = mk(0,1,0, 32'h18, 32'h08, 32'h00000000, 0,0,0);
      vt[12] = mk(0,1,1, 32'h1C, 32'h18, 32'h00000006, 1,0,1);
      vt[13] = mk(0,0,0, 32'h20, 32'h1C, 32'h00000007, 1,0,1);
      // Jump beats branch; then a backward branch.
      vt[14] = mk(0,0,0, 32'h04, 32'h00, 32'h08000010, 1,0,1);
      vt[15] = mk(0,1,1, 32'h40, 32'h00, 32'h00000000, 0,0,0);
      vt[16] = mk(0,0,0, 32'h44, 32'h40, 32'h00000010, 1,0,1);
      vt[17] = mk(0,0,0, 32'h48, 32'h44, 32'h1000FFFE, 1,0,1);
      vt[18] = mk(0,1,0, 32'h40, 32'h44, 32'h00000000, 0,0,0);
      vt[19] = mk(0,0,0, 32'h44, 32'h40, 32'h00000010, 1,0,1);
      // Address wrap past 0xFC.
      vt[20] = mk(0,0,0, 32'h004, 32'h000, 32'h0800003E, 1,0,1);
      vt[21] = mk(0,0,1, 32'h0F8, 32'h000, 32'h00000000, 0,0,0);
      vt[22] = mk(0,0,0, 32'h0FC, 32'h0F8, 32'h0000003E, 1,0,1);
      vt[23] = mk(0,0,0, 32'h100, 32'h0FC, 32'h0000003F, 1,0,1);
      vt[24] = mk(0,0,0, 32'h104, 32'h100, 32'h0800003E, 1,0,1);
      vt[25] = mk(0,0,0, 32'h108, 32'h104, 32'hAC410000, 1,0,1);
      // HALT word at 0xFC: stall delays it, then HALT ignores everything.
      vt[26] = mk(0,0,0, 32'h004, 32'h000, 32'h0800003E, 1,0,1);
      vt[27] = mk(0,0,1, 32'h0F8, 32'h000, 32'h00000000, 0,0,0);
      vt[28] = mk(0,0,0, 32'h0FC, 32'h0F8, 32'h0000003E, 1,0,1);
      vt[29] = mk(0,0,0, 32'h100, 32'h0FC, 32'hFC000000, 1,0,1);
      vt[30] = mk(1,0,0, 32'h100, 32'h0FC, 32'hFC000000, 1,0,1);
      vt[31] = mk(0,0,0, 32'h100, 32'h0FC, 32'h00000000, 0,1,0);
      vt[32] = mk(0,1,1, 32'h100, 32'h0FC, 32'h00000000, 0,1,0);
      vt[33] = mk(1,0,0, 32'h100, 32'h0FC, 32'h00000000, 0,1,0);

      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (2) tick();
      for (int i = 0; i < 64; i++) prog(i, 32'(i));
      prog(0, 32'h00430820);
      prog(1, 32'hAC410000);
      prog(2, 32'h8C440000);
      reset_release("seq");
      run_range(0, 7, "seq");

      reset_assert();
      prog(2, 32'h10000003);
      reset_release("br");
      run_range(8, 13, "br");

      reset_assert();
      prog(0, 32'h08000010);
      prog(17, 32'h1000FFFE);
      reset_release("jmp");
      run_range(14, 19, "jmp");

      reset_assert();
      prog(0, 32'h0800003E);
      reset_release("wrap");
      run_range(20, 25, "wrap");

      reset_assert();
      prog(63, 32'hFC000000);
      reset_release("halt");
      run_range(26, 33, "halt");

      // Asynchronous reset between edges while a taken branch is pending.
      reset_assert();
      prog(0, 32'h00430820);
      reset_release("mid");
      repeat (3) tick();
      check("mid pre ir", ir_out(), 32'h10000003);
      branch_taken = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("mid async pc", pc, 32'h0);
      check("mid async pc_ir", pc_ir, 32'h0);
      check("mid async ir", ir_out(), 32'h0);
      check("mid async valid", 32'(instr_valid), 32'h0);
      check("mid async halted", 32'(halted), 32'h0);
      branch_taken = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("mid first pc_ir", pc_ir, 32'h0);
      check("mid first pc", pc, 32'h4);
      check("mid first ir", ir_out(), 32'h00430820);

      // Same-cycle write of the fetched word returns the old contents.
      prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'h11111111;
      tick();
      prog_we = 1'b0;
      check("wr old ir", ir_out(), 32'hAC410000);
      check("wr old pc", pc, 32'h8);
      // Write lands during a stall while fetch state holds.
      stall = 1'b1; prog_we = 1'b1; prog_addr = 6'd2; prog_data = 32'h22222222;
      tick();
      prog_we = 1'b0; stall = 1'b0;
      check("wr stall pc", pc, 32'h8);
      check("wr stall ir", ir_out(), 32'hAC410000);
      tick();
      check("wr new ir", ir_out(), 32'h22222222);
      check("wr new pc_ir", pc_ir, 32'h8);
      reset_assert();
      reset_release("keep");
      repeat (2) tick();
      check("keep ir", ir_out(), 32'h11111111);
      check("keep pc_ir", pc_ir, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
